// File: rtl/crypto_pkg.sv
// ============================================================================
// Module      : crypto_pkg
// Description : Shared widths, NetFPGA tuser field offsets and tstrb popcount
//               for the crypto datapath.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package crypto_pkg;

    localparam int C_DEF_DATA_WIDTH  = 256;
    localparam int C_DEF_TUSER_WIDTH = 128;
    localparam int C_DEF_KEY_WIDTH   = 32;

    // Widest tstrb the popcount helper accepts (1024-bit tdata).
    localparam int C_MAX_STRB_WIDTH  = 128;

    // NetFPGA tuser layout
    localparam int C_TUSER_LEN_LSB      = 0;
    localparam int C_TUSER_LEN_MSB      = 15;
    localparam int C_TUSER_SRC_PORT_LSB = 16;
    localparam int C_TUSER_SRC_PORT_MSB = 23;
    localparam int C_TUSER_DST_PORT_LSB = 24;
    localparam int C_TUSER_DST_PORT_MSB = 31;

    function automatic logic [7:0] popcount_strb(input logic [C_MAX_STRB_WIDTH-1:0] strb);
        logic [7:0] cnt;
        cnt = '0;
        for (int i = 0; i < C_MAX_STRB_WIDTH; i++) begin
            cnt = cnt + 8'(strb[i]);
        end
        return cnt;
    endfunction

endpackage

`default_nettype wire

// File: rtl/axis_skid_buffer.sv
// ============================================================================
// Module      : axis_skid_buffer
// Description : Generic two-entry skid buffer with a registered upstream ready.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    input  logic             i_ready
);

    logic             r_main_valid;
    logic             r_skid_valid;
    logic             r_ready;
    logic [WIDTH-1:0] r_main_data;
    logic [WIDTH-1:0] r_skid_data;

    logic             w_accept;
    logic             w_main_free;
    logic             w_main_valid_nxt;
    logic             w_skid_valid_nxt;
    logic             w_main_load_skid;
    logic             w_main_load_in;
    logic             w_skid_load;

    // r_ready mirrors an empty skid, so an accept never coincides with a full skid.
    always_comb begin
        w_accept         = i_valid & r_ready;
        w_main_free      = ~r_main_valid | i_ready;
        w_main_valid_nxt = r_main_valid;
        w_skid_valid_nxt = r_skid_valid;
        w_main_load_skid = 1'b0;
        w_main_load_in   = 1'b0;
        w_skid_load      = 1'b0;
        if (w_main_free) begin
            if (r_skid_valid) begin
                w_main_load_skid = 1'b1;
                w_main_valid_nxt = 1'b1;
                w_skid_valid_nxt = 1'b0;
            end else begin
                w_main_load_in   = w_accept;
                w_main_valid_nxt = w_accept;
                w_skid_valid_nxt = 1'b0;
            end
        end else begin
            w_skid_load      = w_accept;
            w_skid_valid_nxt = r_skid_valid | w_accept;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_ready      <= 1'b0;
            r_main_data  <= '0;
            r_skid_data  <= '0;
        end else begin
            r_main_valid <= w_main_valid_nxt;
            r_skid_valid <= w_skid_valid_nxt;
            r_ready      <= ~w_skid_valid_nxt;
            if (w_main_load_skid) begin
                r_main_data <= r_skid_data;
            end else if (w_main_load_in) begin
                r_main_data <= i_data;
            end
            if (w_skid_load) begin
                r_skid_data <= i_data;
            end
        end
    end

    assign o_ready = r_ready;
    assign o_data  = r_main_data;
    assign o_valid = r_main_valid;

endmodule

`default_nettype wire

// File: rtl/crypto_key_latch.sv
// ============================================================================
// Module      : crypto_key_latch
// Description : Registers the AXI4-Stream, latches the key once per packet and
//               keeps packet/byte statistics.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module crypto_key_latch
    import crypto_pkg::*;
#(
    parameter int C_AXIS_DATA_WIDTH  = C_DEF_DATA_WIDTH,
    parameter int C_AXIS_TUSER_WIDTH = C_DEF_TUSER_WIDTH,
    parameter int KEY_WIDTH          = C_DEF_KEY_WIDTH
) (
    input  logic                            axi_aclk,
    input  logic                            axi_reset,

    input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                            s_axis_tlast,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,

    output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
    output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                            m_axis_tlast,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic [KEY_WIDTH-1:0]            m_axis_key,

    input  logic [KEY_WIDTH-1:0]            key_in,
    input  logic                            stat_clear,
    output logic [31:0]                     pkt_count,
    output logic [31:0]                     byte_count
);

    localparam int C_STRB_WIDTH = C_AXIS_DATA_WIDTH / 8;
    localparam int C_BUF_WIDTH  = KEY_WIDTH + 1 + C_AXIS_TUSER_WIDTH + C_STRB_WIDTH
                                  + C_AXIS_DATA_WIDTH;

    logic                        r_sop;
    logic [KEY_WIDTH-1:0]        r_pkt_key;
    logic [31:0]                 r_pkt_count;
    logic [31:0]                 r_byte_count;

    logic                        w_accept;
    logic [KEY_WIDTH-1:0]        w_beat_key;
    logic [C_MAX_STRB_WIDTH-1:0] w_strb_ext;
    logic [7:0]                  w_beat_bytes;
    logic [C_BUF_WIDTH-1:0]      w_buf_in;
    logic [C_BUF_WIDTH-1:0]      w_buf_out;

    assign w_accept     = s_axis_tvalid & s_axis_tready;
    // The first beat uses the live key so single-beat packets need no extra cycle.
    assign w_beat_key   = r_sop ? key_in : r_pkt_key;
    assign w_strb_ext   = C_MAX_STRB_WIDTH'(s_axis_tstrb);
    assign w_beat_bytes = popcount_strb(w_strb_ext);

    assign w_buf_in = {w_beat_key, s_axis_tlast, s_axis_tuser, s_axis_tstrb, s_axis_tdata};

    always_ff @(posedge axi_aclk or posedge axi_reset) begin
        if (axi_reset) begin
            r_sop     <= 1'b1;
            r_pkt_key <= '0;
        end else if (w_accept) begin
            r_sop <= s_axis_tlast;
            if (r_sop) begin
                r_pkt_key <= key_in;
            end
        end
    end

    // A clear coinciding with an accept discards that beat's contribution.
    always_ff @(posedge axi_aclk or posedge axi_reset) begin
        if (axi_reset) begin
            r_pkt_count  <= '0;
            r_byte_count <= '0;
        end else if (stat_clear) begin
            r_pkt_count  <= '0;
            r_byte_count <= '0;
        end else if (w_accept) begin
            r_byte_count <= r_byte_count + 32'(w_beat_bytes);
            if (s_axis_tlast) begin
                r_pkt_count <= r_pkt_count + 32'd1;
            end
        end
    end

    axis_skid_buffer #(
        .WIDTH (C_BUF_WIDTH)
    ) u_skid (
        .clk     (axi_aclk),
        .rst     (axi_reset),
        .i_data  (w_buf_in),
        .i_valid (s_axis_tvalid),
        .o_ready (s_axis_tready),
        .o_data  (w_buf_out),
        .o_valid (m_axis_tvalid),
        .i_ready (m_axis_tready)
    );

    assign {m_axis_key, m_axis_tlast, m_axis_tuser, m_axis_tstrb, m_axis_tdata} = w_buf_out;

    assign pkt_count  = r_pkt_count;
    assign byte_count = r_byte_count;

endmodule

`default_nettype wire
